// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU sharing arbiter: op codes, FSM states and
// the illegal-op check.
package alu_defs;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic is_illegal_op(input logic [2:0] op);
    return (op == 3'b011) || (op == 3'b111);
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arbiter2.sv
// Two-input round-robin grant: on a tie the requester that was not granted
// last time wins; a lone requester always wins.
module rr_arbiter2 (
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant    = 2'b00;
    o_grant[0] = i_req[0] & (~i_req[1] | i_last_grant);
    o_grant[1] = i_req[1] & (~i_req[0] | ~i_last_grant);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two valid/ready requesters,
// one operation in flight, operands and results registered.
module alu_arbiter
  import alu_defs::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [OPW-1:0]   req_op0,
  input  logic [OPW-1:0]   req_op1,
  input  logic [1:0]       req_unsig,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_overflow,
  output logic             rsp_compout,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  output logic             alu_unsig,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_overflow,
  input  logic             alu_compout,
  output logic             busy
);

  state_t           r_state;
  logic             r_last_grant;
  logic             r_id;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [OPW-1:0]   r_op;
  logic             r_unsig;
  logic [1:0]       r_rsp_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_overflow;
  logic             r_compout;
  logic             r_err;
  logic             r_busy;
  logic [1:0]       w_grant;

  rr_arbiter2 u_rr (
    .i_req        (req_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  // Grant is offered only in IDLE and never while reset is held.
  assign req_ready = (r_state == ST_IDLE && !reset) ? w_grant : 2'b00;

  assign alu_a        = r_a;
  assign alu_b        = r_b;
  assign alu_op       = r_op;
  assign alu_unsig    = r_unsig;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_result   = r_result;
  assign rsp_overflow = r_overflow;
  assign rsp_compout  = r_compout;
  assign rsp_err      = r_err;
  assign busy         = r_busy;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= '0;
      r_unsig      <= 1'b0;
      r_rsp_valid  <= 2'b00;
      r_result     <= '0;
      r_overflow   <= 1'b0;
      r_compout    <= 1'b0;
      r_err        <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|req_valid) begin
            r_id         <= w_grant[1];
            r_last_grant <= w_grant[1];
            r_a          <= w_grant[1] ? req_a1  : req_a0;
            r_b          <= w_grant[1] ? req_b1  : req_b0;
            r_op         <= w_grant[1] ? req_op1 : req_op0;
            r_unsig      <= w_grant[1] ? req_unsig[1] : req_unsig[0];
            r_busy       <= 1'b1;
            r_state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (is_illegal_op(r_op)) begin
            r_result   <= '0;
            r_overflow <= 1'b0;
            r_compout  <= 1'b0;
            r_err      <= 1'b1;
          end else begin
            r_result   <= alu_out;
            r_overflow <= alu_overflow;
            r_compout  <= alu_compout;
            r_err      <= 1'b0;
          end
          r_rsp_valid <= r_id ? 2'b10 : 2'b01;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready[r_id]) begin
            r_rsp_valid <= 2'b00;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
